hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 34 +++
 rtl/hazard_fwd_mux.sv | 41 ++++
 rtl/hazard_unit.sv | 116 +++++++++++
 tb/tb_hazard_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared CPU definitions: writeback-select encodings, shadow pipeline entry
// layout and the hazard FSM state type.
package hazard_unit_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned XLEN     = 32;

    typedef enum logic [1:0] {
        WD_ALU  = 2'd0,
        WD_DRAM = 2'd1,
        WD_PC4  = 2'd2,
        WD_IMM  = 2'd3
    } wd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] wR;
        logic             we;
        logic             is_load;
    } shadow_t;

    localparam int unsigned SHADOW_W = $bits(shadow_t);

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_e;

    // x0 writes are architecturally discarded, so they never produce a value.
    function automatic logic is_producer(input shadow_t e);
        return e.valid && e.we && (e.wR != '0);
    endfunction

endpackage

// File: rtl/hazard_fwd_mux.sv
// Per-operand producer search over the shadow pipeline (EX > MEM > WB).
module hazard_fwd_mux
    import hazard_unit_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             used,
    input  shadow_t          ex,
    input  shadow_t          mem,
    input  shadow_t          wb,
    input  logic [XLEN-1:0]  ex_wD,
    input  logic [XLEN-1:0]  mem_wD,
    input  logic [XLEN-1:0]  wb_wD,
    output logic             op,
    output logic [XLEN-1:0]  f,
    output logic             load_use
);

    always_comb begin
        op       = 1'b0;
        f        = '0;
        load_use = 1'b0;
        if (used && (rs != '0)) begin
            // A load in EX has no data yet: it blocks the search instead of forwarding.
            if (is_producer(ex) && (ex.wR == rs)) begin
                if (ex.is_load) begin
                    load_use = 1'b1;
                end else begin
                    op = 1'b1;
                    f  = ex_wD;
                end
            end else if (is_producer(mem) && (mem.wR == rs)) begin
                op = 1'b1;
                f  = mem_wD;
            end else if (is_producer(wb) && (wb.wR == rs)) begin
                op = 1'b1;
                f  = wb_wD;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: shadow EX/MEM/WB tracking, operand forwarding,
// load-use stall, redirect flush and event counters.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rR1,
    input  logic [REG_W-1:0] id_rR2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_wR,
    input  logic             id_rf_we,
    input  logic [1:0]       id_wd_sel,
    input  logic             ex_redirect,
    input  logic [XLEN-1:0]  ex_wD,
    input  logic [XLEN-1:0]  mem_wD,
    input  logic [XLEN-1:0]  wb_wD,
    output logic             rD1_op,
    output logic             rD2_op,
    output logic [XLEN-1:0]  rD1_f,
    output logic [XLEN-1:0]  rD2_f,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    shadow_t   ex_s, mem_s, wb_s;
    shadow_t   id_entry;
    hz_state_e state;
    logic      lu1, lu2;
    logic      lu_stall;

    hazard_fwd_mux u_fwd_rs1 (
        .rs       (id_rR1),
        .used     (id_rs1_used),
        .ex       (ex_s),
        .mem      (mem_s),
        .wb       (wb_s),
        .ex_wD    (ex_wD),
        .mem_wD   (mem_wD),
        .wb_wD    (wb_wD),
        .op       (rD1_op),
        .f        (rD1_f),
        .load_use (lu1)
    );

    hazard_fwd_mux u_fwd_rs2 (
        .rs       (id_rR2),
        .used     (id_rs2_used),
        .ex       (ex_s),
        .mem      (mem_s),
        .wb       (wb_s),
        .ex_wD    (ex_wD),
        .mem_wD   (mem_wD),
        .wb_wD    (wb_wD),
        .op       (rD2_op),
        .f        (rD2_f),
        .load_use (lu2)
    );

    // A redirect discards the dependent instruction anyway, so it wins over the stall.
    always_comb begin
        lu_stall    = (lu1 || lu2) && !ex_redirect;
        stall_pc    = lu_stall;
        stall_if_id = lu_stall;
        flush_if_id = ex_redirect;
        flush_id_ex = ex_redirect || lu_stall;
    end

    always_comb begin
        id_entry.valid   = 1'b1;
        id_entry.wR      = id_wR;
        id_entry.we      = id_rf_we;
        id_entry.is_load = (id_wd_sel == WD_DRAM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_s  <= '0;
            mem_s <= '0;
            wb_s  <= '0;
        end else begin
            wb_s  <= mem_s;
            mem_s <= ex_s;
            ex_s  <= (id_valid && !flush_id_ex) ? id_entry : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:      state <= lu_stall ? LU_STALL : RUN;
                LU_STALL: state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (ex_redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic against an instruction-history reference model.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rR1, id_rR2, id_wR;
    logic        id_rs1_used, id_rs2_used, id_rf_we;
    logic [1:0]  id_wd_sel;
    logic        ex_redirect;
    logic [31:0] ex_wD, mem_wD, wb_wD;
    logic        rD1_op, rD2_op;
    logic [31:0] rD1_f, rD2_f;
    logic        stall_pc, stall_if_id, flush_if_id, flush_id_ex;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rR1      (id_rR1),
        .id_rR2      (id_rR2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_wR       (id_wR),
        .id_rf_we    (id_rf_we),
        .id_wd_sel   (id_wd_sel),
        .ex_redirect (ex_redirect),
        .ex_wD       (ex_wD),
        .mem_wD      (mem_wD),
        .wb_wD       (wb_wD),
        .rD1_op      (rD1_op),
        .rD2_op      (rD2_op),
        .rD1_f       (rD1_f),
        .rD2_f       (rD2_f),
        .stall_pc    (stall_pc),
        .stall_if_id (stall_if_id),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the last three issued instructions, youngest first.
    typedef struct {
        bit          v;
        int unsigned rd;
        bit          we;
        bit          ld;
    } ins_t;

    ins_t        hist[3];
    logic [31:0] m_stall_cnt = 0;
    logic [31:0] m_flush_cnt = 0;

    task automatic fwd_ref(input bit used, input int unsigned r,
                           output bit op, output logic [31:0] f, output bit lu);
        bit found = 0;
        op = 0; f = 0; lu = 0;
        if (used && r != 0) begin
            for (int i = 0; i < 3; i++) begin
                if (!found && hist[i].v && hist[i].we && hist[i].rd == r) begin
                    found = 1;
                    if (i == 0 && hist[i].ld) lu = 1;
                    else begin
                        op = 1;
                        f  = (i == 0) ? ex_wD : (i == 1) ? mem_wD : wb_wD;
                    end
                end
            end
        end
    endtask

    // Compare combinational outputs with the model, then advance one clock.
    task automatic step();
        bit op1, op2, lu1, lu2, stall;
        logic [31:0] f1, f2;
        #2;
        fwd_ref(id_rs1_used, id_rR1, op1, f1, lu1);
        fwd_ref(id_rs2_used, id_rR2, op2, f2, lu2);
        stall = (lu1 || lu2) && !ex_redirect;
        if (!rst) begin
            check("rD1_op", rD1_op, op1);
            check("rD1_f", rD1_f, f1);
            check("rD2_op", rD2_op, op2);
            check("rD2_f", rD2_f, f2);
            check("stall_pc", stall_pc, stall);
            check("stall_if_id", stall_if_id, stall);
            check("flush_if_id", flush_if_id, ex_redirect);
            check("flush_id_ex", flush_id_ex, stall || ex_redirect);
        end
        if (rst) begin
            for (int i = 0; i < 3; i++) hist[i].v = 0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0].v  = id_valid && !(stall || ex_redirect);
            hist[0].rd = id_wR;
            hist[0].we = id_rf_we;
            hist[0].ld = (id_wd_sel == WD_DRAM);
            if (stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (ex_redirect && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
        end
        @(posedge clk);
        #1;
        check("stall_cnt", stall_cnt, m_stall_cnt);
        check("flush_cnt", flush_cnt, m_flush_cnt);
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; id_rR1 = 0; id_rR2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_wR = 0; id_rf_we = 0; id_wd_sel = WD_ALU; ex_redirect = 0;
        ex_wD = 0; mem_wD = 0; wb_wD = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input bit ld);
        idle();
        id_valid = 1; id_wR = rd; id_rf_we = 1; id_wd_sel = ld ? WD_DRAM : WD_ALU;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
        idle();
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        id_rR1 = 5; id_rs1_used = 1; id_rR2 = 6; id_rs2_used = 1;
        #1;
        check("rst_rD1_op", rD1_op, 0);
        check("rst_stall", stall_pc, 0);
        check("rst_flush", flush_id_ex, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        step();

        // Test 1: ADD x5 in EX forwards to rs1
        issue(5, 0); step();
        idle(); id_rR1 = 5; id_rs1_used = 1; ex_wD = 32'h1234;
        #1;
        check("t1_op", rD1_op, 1);
        check("t1_f", rD1_f, 32'h1234);
        check("t1_stall", stall_pc, 0);
        step();

        // Test 2: LW x6 in EX, rs2 reads x6
        do_reset();
        issue(6, 1); step();
        idle(); id_valid = 1; id_rR2 = 6; id_rs2_used = 1; id_wR = 9; id_rf_we = 1;
        #1;
        check("t2_stall_pc", stall_pc, 1);
        check("t2_stall_if_id", stall_if_id, 1);
        check("t2_flush_id_ex", flush_id_ex, 1);
        step();
        check("t2_stall_cnt", stall_cnt, 1);
        mem_wD = 32'hCAFE;
        #1;
        check("t2_op", rD2_op, 1);
        check("t2_f", rD2_f, 32'hCAFE);
        check("t2_nostall", stall_pc, 0);
        step();

        // Test 3: x0 destination never forwards
        issue(0, 0); step();
        idle(); id_rs1_used = 1; id_rs2_used = 1; ex_wD = 32'hFFFF;
        #1;
        check("t3_op1", rD1_op, 0);
        check("t3_op2", rD2_op, 0);
        step();

        // Test 4: x7 in EX and MEM, EX wins
        issue(7, 0); step();
        issue(7, 0); step();
        idle(); id_rR1 = 7; id_rs1_used = 1; ex_wD = 1; mem_wD = 2;
        #1;
        check("t4_op", rD1_op, 1);
        check("t4_f", rD1_f, 1);
        step();

        // Test 5: redirect coincides with load-use
        do_reset();
        issue(6, 1); step();
        idle(); id_valid = 1; id_rR1 = 6; id_rs1_used = 1; ex_redirect = 1;
        #1;
        check("t5_flush_if_id", flush_if_id, 1);
        check("t5_flush_id_ex", flush_id_ex, 1);
        check("t5_stall_pc", stall_pc, 0);
        step();
        check("t5_flush_cnt", flush_cnt, 1);
        check("t5_stall_cnt", stall_cnt, 0);
        ex_redirect = 0;
        step();

        // Test 6: reset during LU_STALL
        issue(6, 1); step();
        idle(); id_valid = 1; id_rR2 = 6; id_rs2_used = 1;
        step();
        rst = 1; step();
        rst = 0;
        #1;
        check("t6_stall_pc", stall_pc, 0);
        check("t6_flush_id_ex", flush_id_ex, 0);
        check("t6_rD2_op", rD2_op, 0);
        check("t6_rD2_f", rD2_f, 0);
        check("t6_stall_cnt", stall_cnt, 0);
        check("t6_flush_cnt", flush_cnt, 0);
        step();

        // Randomized traffic over a small register set to provoke dependencies
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 99) < 2);
            id_valid    = ($urandom_range(0, 9) < 8);
            id_rR1      = 5'($urandom_range(0, 3));
            id_rR2      = 5'($urandom_range(0, 3));
            id_rs1_used = $urandom_range(0, 1) != 0;
            id_rs2_used = $urandom_range(0, 1) != 0;
            id_wR       = 5'($urandom_range(0, 3));
            id_rf_we    = ($urandom_range(0, 9) < 8);
            id_wd_sel   = 2'($urandom_range(0, 3));
            ex_redirect = ($urandom_range(0, 9) == 0);
            ex_wD       = $urandom;
            mem_wD      = $urandom;
            wb_wD       = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
